// File: rtl/npc_pkg.sv
// Shared definitions for the fetch front end: IFU state encoding,
// default reset PC and the canonical NOP encoding.
package npc_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/ifu_if.sv
// Fetch unit bus bundle: instruction memory request/response port
// plus the instruction port towards decode.
interface ifu_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [DW-1:0] imem_resp_data;
  logic          inst_valid;
  logic          inst_ready;
  logic [DW-1:0] inst;
  logic [AW-1:0] inst_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data,
    output inst_valid,
    output inst,
    output inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    output inst_ready
  );

endinterface

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush; registered storage,
// push accepted when full only if a pop happens in the same cycle.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC, single-outstanding imem requests, buffer to decode.
// Define IFU_PERF_CNT_EN to add fetch/stall performance counters.
module ifu
  import npc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF),
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ifu_if.master                 bus,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = ADDR_WIDTH + DATA_WIDTH;

  ifu_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] req_pc_q;
  logic                  req_v;
  logic                  push;
  logic                  pop;
  logic                  fire;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic [FW-1:0]         fifo_dout;
  logic                  lint_unused;

  assign lint_unused = ^{full, redirect_pc[1:0]};
  assign fire        = req_v && bus.imem_req_ready;
  assign pop         = !empty && bus.inst_ready && !redirect_valid;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_v   = 1'b0;
    push    = 1'b0;
    unique case (state_q)
      FETCH: begin
        req_v = (count < CW'(FIFO_DEPTH)) && !redirect_valid;
        if (req_v && bus.imem_req_ready) begin
          pc_d    = pc_q + ADDR_WIDTH'(4);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_resp_valid) begin
          push    = !redirect_valid;
          state_d = FETCH;
        end else if (redirect_valid) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // A response landing with a new redirect still retires the
        // outstanding request, so nothing is left to drop.
        if (bus.imem_resp_valid)
          state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_valid)
      pc_d = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (fire)
        req_pc_q <= pc_q;
    end
  end

  ifu_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({req_pc_q, bus.imem_resp_data}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign bus.imem_req_valid = !rst && req_v;
  assign bus.imem_req_addr  = rst ? '0 : pc_q;
  assign bus.inst_valid     = !rst && !empty;
  assign bus.inst           = rst ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign bus.inst_pc        = rst ? '0 : fifo_dout[FW-1:DATA_WIDTH];

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (pop)
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (empty)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu.sv
// Directed bench for ifu: per-cycle vector table plus redirect/flush
// and performance counter sequences.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  ifu_if bus ();

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifu dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          irdy;
    bit          redir;
    logic [31:0] rpc;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_iv;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tv[$];

  int n_cmp = 0;
  int n_bad = 0;

  bit          pend;
  int          wait_cnt;
  int          mem_lat;
  logic [31:0] pend_addr;

  logic        o_rv;
  logic [31:0] o_addr;
  logic        o_iv;
  logic [31:0] o_inst;
  logic [31:0] o_pc;

  function automatic logic [31:0] wf(logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic vec_t mk(bit r, bit rd, bit ir, bit rv_in,
                              logic [31:0] rp, bit erv,
                              logic [31:0] ea, bit eiv,
                              logic [31:0] ep);
    vec_t v;
    v.rst = r; v.rdy = rd; v.irdy = ir; v.redir = rv_in;
    v.rpc = rp; v.e_rv = erv; v.e_addr = ea;
    v.e_iv = eiv; v.e_pc = ep;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: sample DUT at negedge, then advance the memory model.
  task automatic tick();
    @(negedge clk);
    o_rv   = bus.imem_req_valid;
    o_addr = bus.imem_req_addr;
    o_iv   = bus.inst_valid;
    o_inst = bus.inst;
    o_pc   = bus.inst_pc;
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      pend      = 1'b1;
      pend_addr = bus.imem_req_addr;
      wait_cnt  = mem_lat;
    end
    @(posedge clk);
    #1;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    if (rst) begin
      pend = 1'b0;
    end else if (pend) begin
      if (wait_cnt <= 1) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = wf(pend_addr);
        pend                = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  endtask

  initial begin
    bit got;

    // reset, then 1-cycle memory streaming
    tv.push_back(mk(1,1,1,0,0, 0,32'h0,0,32'h0));
    tv.push_back(mk(1,1,1,0,0, 0,32'h0,0,32'h0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_0000,0,0));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_0004,1,32'h8000_0000));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_0008,1,32'h8000_0004));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_000C,1,32'h8000_0008));
    // reset while a response is due
    tv.push_back(mk(1,1,1,0,0, 0,32'h0,0,32'h0));
    // backpressure from decode
    tv.push_back(mk(0,1,0,0,0, 1,32'h8000_0000,0,0));
    tv.push_back(mk(0,1,0,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,0,0,0, 1,32'h8000_0004,1,32'h8000_0000));
    tv.push_back(mk(0,1,0,0,0, 0,0,1,32'h8000_0000));
    tv.push_back(mk(0,1,0,0,0, 0,0,1,32'h8000_0000));
    tv.push_back(mk(0,1,0,0,0, 0,0,1,32'h8000_0000));
    tv.push_back(mk(0,1,1,0,0, 0,0,1,32'h8000_0000));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_0008,1,32'h8000_0004));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_000C,1,32'h8000_0008));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    // redirect in FETCH, unaligned target
    tv.push_back(mk(0,1,1,1,32'h8000_0013, 0,0,1,32'h8000_000C));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_0010,0,0));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h8000_0014,1,32'h8000_0010));
    // redirect in WAIT with same-cycle response, then wrap
    tv.push_back(mk(0,1,1,1,32'hFFFF_FFFC, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'hFFFF_FFFC,0,0));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h0000_0000,1,32'hFFFF_FFFC));
    tv.push_back(mk(0,1,1,0,0, 0,0,0,0));
    tv.push_back(mk(0,1,1,0,0, 1,32'h0000_0004,1,32'h0000_0000));

    rst                 = 1'b1;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    bus.imem_req_ready  = 1'b0;
    bus.inst_ready      = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    pend                = 1'b0;
    wait_cnt            = 0;
    pend_addr           = '0;
    mem_lat             = 1;

    for (int i = 0; i < tv.size(); i++) begin
      rst                = tv[i].rst;
      bus.imem_req_ready = tv[i].rdy;
      bus.inst_ready     = tv[i].irdy;
      redirect_valid     = tv[i].redir;
      redirect_pc        = tv[i].rpc;
      tick();
      chk($sformatf("v%0d req_valid", i), 32'(o_rv), 32'(tv[i].e_rv));
      if (tv[i].e_rv || tv[i].rst)
        chk($sformatf("v%0d req_addr", i), o_addr, tv[i].e_addr);
      chk($sformatf("v%0d inst_valid", i), 32'(o_iv), 32'(tv[i].e_iv));
      if (tv[i].e_iv || tv[i].rst) begin
        chk($sformatf("v%0d inst_pc", i), o_pc, tv[i].e_pc);
        chk($sformatf("v%0d inst", i), o_inst,
            tv[i].rst ? 32'h0 : wf(tv[i].e_pc));
      end
    end

    // redirect in WAIT, stale response two cycles later
    redirect_valid     = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    rst                = 1'b1;
    tick();
    rst     = 1'b0;
    mem_lat = 3;
    tick();
    chk("t3 first req_valid", 32'(o_rv), 32'h1);
    chk("t3 first req_addr", o_addr, 32'h8000_0000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    chk("t3 wait req_valid", 32'(o_rv), 32'h0);
    redirect_valid = 1'b0;
    tick();
    chk("t3 flush req_valid", 32'(o_rv), 32'h0);
    tick();
    chk("t3 drop req_valid", 32'(o_rv), 32'h0);
    chk("t3 drop inst_valid", 32'(o_iv), 32'h0);
    tick();
    chk("t3 new req_valid", 32'(o_rv), 32'h1);
    chk("t3 new req_addr", o_addr, 32'h8000_0100);
    chk("t3 fifo empty", 32'(o_iv), 32'h0);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      got = o_iv;
    end
    chk("t3 inst arrives", 32'(got), 32'h1);
    if (got) begin
      chk("t3 inst_pc", o_pc, 32'h8000_0100);
      chk("t3 inst", o_inst, wf(32'h8000_0100));
    end

`ifdef IFU_PERF_CNT_EN
    rst     = 1'b1;
    mem_lat = 1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("perf fetch after rst", perf_fetch_cnt, 32'h0);
    chk("perf stall after rst", perf_stall_cnt, 32'h0);
    repeat (2) @(negedge clk);
    chk("perf stall count", perf_stall_cnt, 32'd2);
    chk("perf fetch idle", perf_fetch_cnt, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
